// File: rtl/conv_pkg.sv
// Shared widths and FSM encoding for the sliding-window convolution stage.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package conv_pkg;

  localparam int PIX_W  = 8;
  localparam int PROD_W = 17;
  localparam int ACC_W  = 21;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT,
    DONE
  } conv_state_t;

endpackage

// File: rtl/conv_mac.sv
// Single multiply-accumulate: unsigned pixel times signed tap into a 21-bit accumulator.
// Latency: 1 cycle from operands to the updated accumulator.
// Backpressure: en low holds the accumulator unchanged.
module conv_mac
  import conv_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic [PIX_W-1:0]         pix,
  input  logic [PIX_W-1:0]         tap,
  output logic signed [ACC_W-1:0]  acc
);

  logic signed [PROD_W-1:0] pix_s;
  logic signed [PROD_W-1:0] tap_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;

  // Pixel is zero-extended, tap sign-extended; the true product always fits in 17 bits.
  always_comb begin
    pix_s    = {{(PROD_W-PIX_W){1'b0}}, pix};
    tap_s    = {{(PROD_W-PIX_W){tap[PIX_W-1]}}, tap};
    prod     = pix_s * tap_s;
    prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  end

  // First tap of a window loads the product, so no separate clear cycle is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= load ? prod_ext : acc + prod_ext;
    end
  end

endmodule

// File: rtl/conv_window_engine.sv
// Stride-1 no-padding convolution of one image against NUM_FLT filters; optional ReLU via CONV_RELU_EN.
// Latency: FLT_SIZE^2 MAC cycles per result, first out_valid FLT_SIZE^2+1 cycles after start.
// Backpressure: a result is held stable in OUT until out_ready; no MAC work proceeds meanwhile.
module conv_window_engine
  import conv_pkg::*;
#(
  parameter int IMG_SIZE = 16,
  parameter int FLT_SIZE = 4,
  parameter int NUM_FLT  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              img_data [0:IMG_SIZE*IMG_SIZE-1],
  input  logic [7:0]              filters  [0:NUM_FLT-1][0:FLT_SIZE*FLT_SIZE-1],
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic signed [ACC_W-1:0] out_data,
  output logic [1:0]              out_flt,
  output logic [7:0]              out_row,
  output logic [7:0]              out_col,
  output logic                    busy,
  output logic                    done
);

  localparam int IMG_AW = $clog2(IMG_SIZE*IMG_SIZE);
  localparam int TAP_AW = $clog2(FLT_SIZE*FLT_SIZE);
  localparam int FW     = (NUM_FLT > 1) ? $clog2(NUM_FLT) : 1;
  localparam logic [7:0]    K_LAST = 8'(FLT_SIZE-1);
  localparam logic [7:0]    P_LAST = 8'(IMG_SIZE-FLT_SIZE);
  localparam logic [FW-1:0] F_LAST = FW'(NUM_FLT-1);

  conv_state_t       state;
  logic [FW-1:0]     f;
  logic [7:0]        row;
  logic [7:0]        col;
  logic [7:0]        kr;
  logic [7:0]        kc;
  logic [IMG_AW-1:0] pix_idx;
  logic [TAP_AW-1:0] tap_idx;
  logic              last_result;
  logic signed [ACC_W-1:0] acc;

  // Operand select: window origin plus tap offset, and the matching filter tap.
  always_comb begin
    pix_idx     = IMG_AW'((32'(row) + 32'(kr)) * IMG_SIZE + 32'(col) + 32'(kc));
    tap_idx     = TAP_AW'(32'(kr) * FLT_SIZE + 32'(kc));
    last_result = (f == F_LAST) && (row == P_LAST) && (col == P_LAST);
  end

  conv_mac u_mac (
    .clk  (clk),
    .rst  (rst),
    .en   (state == MAC),
    .load ((kr == 8'd0) && (kc == 8'd0)),
    .pix  (img_data[pix_idx]),
    .tap  (filters[f][tap_idx]),
    .acc  (acc)
  );

  // The accumulator is frozen outside MAC, so it doubles as the held result in OUT.
  always_comb begin
`ifdef CONV_RELU_EN
    out_data = acc[ACC_W-1] ? '0 : acc;
`else
    out_data = acc;
`endif
  end

  // Control FSM with registered handshake, status and tag outputs plus iteration counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      f         <= '0;
      row       <= '0;
      col       <= '0;
      kr        <= '0;
      kc        <= '0;
      out_valid <= 1'b0;
      out_flt   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= MAC;
            busy  <= 1'b1;
            f     <= '0;
            row   <= '0;
            col   <= '0;
            kr    <= '0;
            kc    <= '0;
          end
        end
        MAC: begin
          if (kc == K_LAST) begin
            kc <= '0;
            if (kr == K_LAST) begin
              kr        <= '0;
              state     <= OUT;
              out_valid <= 1'b1;
              out_flt   <= 2'(f);
              out_row   <= row;
              out_col   <= col;
            end else begin
              kr <= kr + 8'd1;
            end
          end else begin
            kc <= kc + 8'd1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (last_result) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= MAC;
              if (col == P_LAST) begin
                col <= '0;
                if (row == P_LAST) begin
                  row <= '0;
                  f   <= f + 1'b1;
                end else begin
                  row <= row + 8'd1;
                end
              end else begin
                col <= col + 8'd1;
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_engine.sv
// Self-checking bench for conv_window_engine: scoreboard of expected results per pass.
// Latency: checks first out_valid 17 cycles after start and done one cycle after the last handshake.
// Backpressure: exercises held-low and random out_ready.
module tb_conv_window_engine;

  localparam int IMG = 16;
  localparam int FLT = 4;
  localparam int NF  = 4;
  localparam int OW  = IMG - FLT + 1;

  typedef struct {
    int f;
    int r;
    int c;
    int d;
  } res_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               out_ready;
  logic [7:0]         img [0:IMG*IMG-1];
  logic [7:0]         flt [0:NF-1][0:FLT*FLT-1];
  logic               out_valid;
  logic signed [20:0] out_data;
  logic [1:0]         out_flt;
  logic [7:0]         out_row;
  logic [7:0]         out_col;
  logic               busy;
  logic               done;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv_window_engine #(.IMG_SIZE(IMG), .FLT_SIZE(FLT), .NUM_FLT(NF)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .img_data  (img),
    .filters   (flt),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_flt   (out_flt),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference dot product computed straight from the bench's own image and filter arrays.
  function automatic int ref_val(input int f, input int r, input int c);
    int s;
    s = 0;
    for (int i = 0; i < FLT; i++) begin
      for (int j = 0; j < FLT; j++) begin
        s += int'(img[(r + i) * IMG + c + j]) * int'($signed(flt[f][i * FLT + j]));
      end
    end
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_flt"}, out_flt, 0);
    chk({tag, "_row"}, out_row, 0);
    chk({tag, "_col"}, out_col, 0);
  endtask

  // One full pass: push all expectations, then pop them as the DUT hands results over.
  task automatic run_pass(input bit rnd, input bit dbl, input int sf, input int sr, input int sc, input int sv);
    int   cyc, last_hs, done_cnt, popped, stall_cnt, spot_cnt;
    bit   first_seen, fin;
    res_t e;
    sb.delete();
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < OW; r++)
        for (int c = 0; c < OW; c++)
          sb.push_back('{f: f, r: r, c: c, d: ref_val(f, r, c)});
    cyc = 0; last_hs = -10; done_cnt = 0; popped = 0; stall_cnt = 0; spot_cnt = 0;
    first_seen = 1'b0; fin = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    cyc = 1;
    #1 start = 1'b0;
    while (!fin && cyc < 40000) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        chk("done_cycle", cyc, last_hs + 1);
        chk("busy_in_done", busy, 1);
      end else if (done_cnt > 0) begin
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done, 0);
        fin = 1'b1;
      end
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        chk("first_valid_cycle", cyc, 17);
      end
      if (rnd && popped == 3 && out_valid && !out_ready && stall_cnt < 5) begin
        stall_cnt++;
        chk("stall_data", out_data, sb[0].d);
        chk("stall_flt", out_flt, sb[0].f);
        chk("stall_row", out_row, sb[0].r);
        chk("stall_col", out_col, sb[0].c);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          chk("res_flt", out_flt, e.f);
          chk("res_row", out_row, e.r);
          chk("res_col", out_col, e.c);
          chk("res_data", out_data, e.d);
          if (e.f == sf && e.r == sr && e.c == sc) begin
            spot_cnt++;
            chk("spot_value", out_data, sv);
          end
        end
        popped++;
        last_hs = cyc;
      end
      @(posedge clk);
      cyc++;
      #1;
      start = dbl && (cyc == 5);
      if (rnd && popped == 3 && stall_cnt < 5) out_ready = 1'b0;
      else out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("pass_done_count", done_cnt, 1);
    chk("pass_results", popped, NF * OW * OW);
    chk("sb_left", sb.size(), 0);
    chk("spot_seen", spot_cnt, 1);
    if (rnd) chk("stall_cycles", stall_cnt, 5);
  endtask

  initial begin
    int hs;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < IMG * IMG; i++) img[i] = 8'd1;
    for (int f = 0; f < NF; f++)
      for (int k = 0; k < FLT * FLT; k++) flt[f][k] = 8'd1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    // All ones: every result 16; a stray start in cycle 5 must be ignored.
    run_pass(1'b0, 1'b1, 0, 0, 0, 16);

    // Ramp image with a single unit tap on filter 0; filter 1 all -1, others random.
    for (int i = 0; i < IMG * IMG; i++) img[i] = 8'(i % 256);
    for (int k = 0; k < FLT * FLT; k++) begin
      flt[0][k] = (k == 0) ? 8'd1 : 8'd0;
      flt[1][k] = 8'hFF;
      flt[2][k] = 8'($urandom_range(0, 255));
      flt[3][k] = 8'($urandom_range(0, 255));
    end
    run_pass(1'b1, 1'b0, 0, 3, 5, 53);

    // Saturated image against negative filter, with a reset in the middle of result 10.
    for (int i = 0; i < IMG * IMG; i++) img[i] = 8'hFF;
    for (int k = 0; k < FLT * FLT; k++) begin
      flt[0][k] = 8'd1;
      flt[1][k] = 8'hFF;
      flt[2][k] = 8'd0;
      flt[3][k] = 8'($urandom_range(0, 255));
    end
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    for (int i = 0; i < 400 && hs < 10; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) hs++;
      @(posedge clk); #1;
    end
    chk("pre_reset_handshakes", hs, 10);
    @(negedge clk);
    chk("pre_reset_busy", busy, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("mid_reset");

`ifdef CONV_RELU_EN
    run_pass(1'b0, 1'b0, 1, 0, 0, 0);
`else
    run_pass(1'b0, 1'b0, 1, 0, 0, -4080);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_engine.md
# conv_window_engine

Sliding-window convolution stage directly downstream of the memory reader datapath. Once the reader has filled the image buffer (IMG_SIZE×IMG_SIZE unsigned bytes) and the NUM_FLT filter buffers (FLT_SIZE×FLT_SIZE signed bytes each), a `start` pulse makes this block compute every valid (no-padding, stride-1) output of every filter. It uses one multiply-accumulate per cycle and streams each result out over a valid/ready handshake.

## Interface
Parameters:
- `IMG_SIZE`, default 16: image edge length in pixels.
- `FLT_SIZE`, default 4: filter edge length.
- `NUM_FLT`, default 4: number of filters.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: one-cycle request to begin a full pass. Sampled only in IDLE.
- `img_data`  in  [7:0] × [0:IMG_SIZE*IMG_SIZE-1]: image, row-major, unsigned.
- `filters`  in  [7:0] × [0:NUM_FLT-1][0:FLT_SIZE*FLT_SIZE-1]: filter taps, row-major, two's-complement signed.
- `out_ready`  in  1: downstream accepts the result this cycle.
- `out_valid`  out  1: `out_data` and the tags below are valid.
- `out_data`  out  21 signed: dot product for the current window and filter.
- `out_flt`  out  2: filter index of the result.
- `out_row`, `out_col`  out  8 each: output coordinates, range 0..IMG_SIZE-FLT_SIZE.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse after the last result is accepted.

## Operation
- States and transitions:
  - IDLE → MAC when `start` is high.
  - MAC → OUT after the tap counter `k` reaches FLT_SIZE²-1.
  - OUT → MAC on handshake, if more results remain.
  - OUT → DONE on handshake of the last result.
  - DONE → IDLE unconditionally.
- Iteration order, outermost to innermost:
  - filter `f` = 0..NUM_FLT-1,
  - then `row`,
  - then `col`,
  - then tap `k` = 0..FLT_SIZE²-1 (row-major inside the window).
- MAC cycle `k`:
  - Tap row `kr` = k / FLT_SIZE, tap column `kc` = k % FLT_SIZE.
  - Pixel = `img_data[(row+kr)*IMG_SIZE + col+kc]`, zero-extended to 9-bit signed.
  - Product = pixel × sign-extended `filters[f][k]`, 17-bit signed.
  - At k=0 the product is loaded into the accumulator (no separate clear cycle). For k>0 it is added.
- Accumulator is 21-bit signed. It holds a worst-case range of ±16×32640 with no overflow.
- OUT state:
  - Holds `out_valid`=1 and keeps the data and tags stable until `out_ready`=1.
  - On handshake, counters advance: col, then row wraps to 0, then f increments.
- Total results per pass: NUM_FLT×(IMG_SIZE-FLT_SIZE+1)² = 676 at defaults.
- Data-stability contract: upstream must keep `img_data` and `filters` stable while `busy`=1. This block does not latch them.
- `start` while `busy`=1 is ignored.
- Reset, including mid-operation:
  - State returns to IDLE.
  - `out_valid`, `busy`, `done` go to 0.
  - Accumulator, `out_data`, `out_flt`, `out_row`, `out_col`, and all counters go to 0.

## Timing
- `start` sampled at edge 0 → first MAC at cycle 1 → `out_valid` high from cycle 17 (FLT_SIZE²+1).
- Minimum period per result is 17 cycles when `out_ready` is held high.
- `out_valid` and the tags are registered, so they have no combinational path from `out_ready`.
- `done` is high for exactly the one cycle in DONE. `busy` drops in the following cycle (IDLE).

## Configuration
- Macro: `CONV_RELU_EN`.
- Defined: a negative accumulator value is presented as 0 on `out_data`; non-negative values pass unchanged.
- Undefined: the raw signed sum is presented.
- Handshake and timing are identical in both builds.

## Structure
- Package `conv_pkg` holds:
  - `PIX_W`=8, `PROD_W`=17, `ACC_W`=21,
  - the state enum `conv_state_t` (IDLE, MAC, OUT, DONE).
- Sub-module `conv_mac`:
  - Inputs: pixel, tap, `load` (high at k=0), enable.
  - Output: registered 21-bit accumulator.
- FSM, counters, operand-select muxes and the output register live in the top module.

## Test plan
- Image all 1, every filter all 1 → 676 results, each 16, in f/row/col order; `done` pulses once after the 676th handshake.
- `img_data[i]` = i%256, filter 0 tap 0 = 1 and the other taps 0 → each filter-0 result equals `img_data[row*16+col]`, e.g. (3,5) → 53.
- Image all 255, filter 1 all 0xFF (−1) → result −4080 without `CONV_RELU_EN`, 0 with it.
- `out_ready` held low 5 cycles in OUT → `out_valid`, `out_data` and the tags stay constant; tags advance by one position only after `out_ready` rises.
- `start` at cycle 0 → `out_valid` first at cycle 17. A second `start` at cycle 5 has no effect on sequence or timing.
- `rst` asserted during MAC of result 10 → next cycle `busy`=0, `out_valid`=0. A new `start` restarts at f=0, (0,0).
